// File: rtl/apb_csr_slave.sv
// APB3 slave front end for the CSR block: turns APB transfers into a 3-bit register
// index, a one-cycle write commit pulse and a one-cycle read strobe.
module apb_csr_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic              o_pready,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pslverr,
    output logic [2:0]        o_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_en,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_rd_en
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [1:0] WAIT_C   = 2'(WAIT_CYCLES);

    logic [0:0]        state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [2:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;

    logic              illegal;
    logic              done;

    // Shift rather than slice so ADDR_W == 5 (no upper bits) stays legal.
    assign illegal = (i_paddr[1:0] != 2'b00) || ((i_paddr >> 5) != '0);
    assign done    = (state_q == S_ACCESS) && (wcnt_q == WAIT_C);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_psel && !i_penable) begin
                    state_d = S_ACCESS;
                    wcnt_d  = 2'd0;
                    addr_d  = i_paddr[4:2];
                    wdata_d = i_pwdata;
                    write_d = i_pwrite;
                    err_d   = illegal;
                end
            end
            S_ACCESS: begin
                // Completion is decided by the counter alone; bus inputs only abort or stretch.
                if (done) begin
                    state_d = S_IDLE;
                end else if (i_psel && i_penable) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 2'd0;
            addr_q  <= 3'b000;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    assign o_pready  = done;
    assign o_pslverr = done && err_q;
    assign o_en      = done && write_q && !err_q;
    assign o_rd_en   = done && !write_q && !err_q;
    assign o_prdata  = o_rd_en ? i_rdata : '0;
    assign o_addr    = addr_q;
    assign o_wdata   = wdata_q;

endmodule

// File: doc/apb_csr_slave.md
# apb_csr_slave

APB3 slave front end for the CSR block. Converts APB transfers into the 3-bit register index and one-cycle write enable consumed by the CSR address decoder, and returns read data from the register bank. Handles wait-state insertion, transfer abort and PSLVERR for illegal addresses. Sits directly upstream of the decoder: `o_addr` drives decoder `i_addr` and `o_en` drives decoder `i_en`.

## Interface
- `ADDR_W`, 8: PADDR width, minimum 5.
- `DATA_W`, 8: PWDATA/PRDATA width, equal to CSR register width.
- `WAIT_CYCLES`, 0: wait states inserted per transfer, range 0..3.

- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_psel`  in  1  APB select.
- `i_penable`  in  1  APB enable.
- `i_pwrite`  in  1  1 = write, 0 = read.
- `i_paddr`  in  ADDR_W  byte address.
- `i_pwdata`  in  DATA_W  write data.
- `o_pready`  out  1  transfer complete.
- `o_prdata`  out  DATA_W  read data, valid with `o_pready` on error-free reads, else 0.
- `o_pslverr`  out  1  error response, valid only with `o_pready`.
- `o_addr`  out  3  register index to decoder.
- `i_rdata`  in  DATA_W  register bank read mux output, selected by `o_addr`, combinational.
- `o_en`  out  1  decoder enable; one-cycle write commit pulse.
- `o_wdata`  out  DATA_W  captured write data to register bank.
- `o_rd_en`  out  1  one-cycle read strobe, for clear-on-read side effects.

## Operation
- Address map: legal iff `i_paddr[1:0]==0` and `i_paddr[ADDR_W-1:5]==0`. Index = `i_paddr[4:2]`, giving 0x00..0x1C onto 3'b000..3'b111.
- FSM states: IDLE, ACCESS. 2-bit wait counter `wcnt`.
- IDLE, `i_psel=1` and `i_penable=0` (bus SETUP cycle):
  - At the edge, capture index into `o_addr`, write flag, `i_pwdata` into `o_wdata`, and the error flag (illegal address).
  - Clear `wcnt`. Go to ACCESS.
- IDLE, `i_psel=1` and `i_penable=1`: protocol violation. Ignore, stay IDLE, no capture.
- ACCESS, `i_psel=1` and `i_penable=1`:
  - While `wcnt<WAIT_CYCLES`: `o_pready=0`, increment `wcnt`.
  - When `wcnt==WAIT_CYCLES`: completing cycle, then go to IDLE.
- Completing cycle outputs:
  - `o_pready=1`. `o_pslverr` = error flag.
  - Write, no error: `o_en=1`.
  - Read, no error: `o_rd_en=1`, `o_prdata=i_rdata`.
  - Error: `o_en=0`, `o_rd_en=0`, `o_prdata=0`.
- ACCESS, `i_psel=0` or `i_penable=0` before completion: abort.
  - Go to IDLE with no `o_en`, `o_rd_en` or `o_pready`.
  - `o_addr` and `o_wdata` keep their captured values.
- `o_pready`, `o_pslverr`, `o_en` and `o_rd_en` decode from the state, `wcnt` and captured flags only, with no combinational path from APB inputs. `o_prdata` is the only output with a combinational path, from `i_rdata` gated by those decodes.
- `o_addr` and `o_wdata` hold their last captured values between transfers. The decoder must be qualified by `o_en` only.

## Timing
- Reset values, applied on the edge where `i_rst=1`: state IDLE, `wcnt=0`, `o_pready=0`, `o_pslverr=0`, `o_prdata=0`, `o_addr=3'b000`, `o_wdata=0`, `o_en=0`, `o_rd_en=0`, error and write flags 0.
- `i_rst` has priority over every other event. Reset during ACCESS abandons the transfer: no `o_en` is issued, the bus sees no `o_pready`, and the master must re-issue after reset.
- Transfer length is 2 + `WAIT_CYCLES` cycles: SETUP cycle, then 1 + `WAIT_CYCLES` ACCESS cycles.
- Back-to-back: a new SETUP is accepted in the cycle immediately after completion. Sustained rate is one transfer per 2 + `WAIT_CYCLES` cycles.
- `o_en` is high for exactly one cycle per committed write, coincident with `o_pready`. The bank commits on that edge.
- `o_addr` is stable from the cycle after SETUP through completion, so `i_rdata` settles before the completing cycle.

## Test plan
- Write, `WAIT_CYCLES=0`: SETUP at T0 with `i_paddr=0x08`, `i_pwdata=0xA5`, ACCESS at T1 -> at T1 `o_pready=1`, `o_en=1`, `o_addr=3'b010`, `o_wdata=0xA5`, `o_pslverr=0`. At T2 `o_en=0`.
- Read, `WAIT_CYCLES=2`: `i_paddr=0x1C`, `i_rdata=0x3C` -> `o_addr=3'b111`. `o_pready=0` for 2 ACCESS cycles, then 1 with `o_prdata=0x3C` and `o_rd_en=1`.
- Illegal addresses, 0x21 and 0x06 -> `o_pready=1`, `o_pslverr=1`, `o_en=0`, `o_prdata=0`.
- Back-to-back writes to 0x00..0x1C with data 0x10..0x17, `WAIT_CYCLES=0` -> completion every 2 cycles. `o_addr` sweeps 000..111, with 8 single-cycle `o_en` pulses.
- Abort: `WAIT_CYCLES=3`, `i_psel` dropped on the 2nd ACCESS cycle -> FSM returns to IDLE, no `o_en` or `o_pready`. The next transfer then completes normally.
- Reset mid-ACCESS write -> next cycle all outputs at reset values, no `o_en` ever asserted for that transfer.
